// File: rtl/divider_pkg.sv
// Shared types and constants for the 4-bit sequential restoring divider.
package divider_pkg;

  localparam int DIV_W    = 4;
  localparam int DIV_ITER = 4;

  localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 4'hF;
  localparam logic [1:0]       CNT_LAST     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // A trial subtract succeeds when the shifted-out bit already exceeds D or no borrow occurred.
  function automatic logic trial_ok(input logic s_msb, input logic no_borrow);
    return s_msb | no_borrow;
  endfunction

endpackage

// File: rtl/AdderSubtractor.sv
// 4-bit ripple adder/subtractor: AS=1 computes In1-In2 with Cout=1 meaning no borrow.
module AdderSubtractor (
  input  logic [3:0] In1,
  input  logic [3:0] In2,
  input  logic       AS,
  output logic [3:0] Result,
  output logic       Cout
);

  logic [4:0] carry_s;
  logic [3:0] in2_x_s;

  assign in2_x_s    = In2 ^ {4{AS}};
  assign carry_s[0] = AS;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign Result[i]    = In1[i] ^ in2_x_s[i] ^ carry_s[i];
    assign carry_s[i+1] = (In1[i] & in2_x_s[i]) | (carry_s[i] & (In1[i] ^ in2_x_s[i]));
  end

  assign Cout = carry_s[4];

endmodule

// File: rtl/seq_divider_ctrl.sv
// Sequential 4-bit restoring divider: one trial subtract per clock through a shared AdderSubtractor.
module seq_divider_ctrl
  import divider_pkg::*;
(
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [DIV_W-1:0] DIVIDEND,
  input  logic [DIV_W-1:0] DIVISOR,
  output logic             BUSY,
  output logic             DONE,
  output logic [DIV_W-1:0] QUOTIENT,
  output logic [DIV_W-1:0] REMAINDER,
  output logic             DIV_ZERO
);

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [DIV_W-1:0] r_q, q_q, d_q;
  logic [DIV_W-1:0] r_d, q_d;
  logic [DIV_W-1:0] quo_q, rem_q;
  logic             dz_q, busy_q, done_q;

  logic [DIV_W:0]   shift_s;
  logic [DIV_W-1:0] diff_s;
  logic             cout_s;
  logic             ok_s;

  assign shift_s = {r_q, q_q[DIV_W-1]};

  AdderSubtractor u_addsub (
    .In1    (shift_s[DIV_W-1:0]),
    .In2    (d_q),
    .AS     (1'b1),
    .Result (diff_s),
    .Cout   (cout_s)
  );

  assign ok_s = trial_ok(shift_s[DIV_W], cout_s);

  // Restore mux: keep the difference on success, otherwise the plain shifted remainder.
  always_comb begin
    r_d = shift_s[DIV_W-1:0];
    q_d = {q_q[DIV_W-2:0], ok_s};
    if (ok_s) begin
      r_d = diff_s;
    end else begin
      r_d = shift_s[DIV_W-1:0];
    end
  end

  // Control FSM with iteration counter, working registers and registered results.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            r_q   <= '0;
            q_q   <= DIVIDEND;
            d_q   <= DIVISOR;
            cnt_q <= 2'd0;
            if (DIVISOR != '0) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end else begin
              // Divide by zero bypasses the datapath entirely.
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              quo_q   <= DIV_ZERO_QUO;
              rem_q   <= DIVIDEND;
              dz_q    <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            quo_q   <= q_d;
            rem_q   <= r_d;
            dz_q    <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= 2'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign QUOTIENT  = quo_q;
  assign REMAINDER = rem_q;
  assign DIV_ZERO  = dz_q;

endmodule

// File: tb/tb_seq_divider_ctrl.sv
// Self-checking bench for seq_divider_ctrl: directed table, exhaustive sweep, random ops and corner sequences.
module tb_seq_divider_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       START;
  logic [3:0] DIVIDEND, DIVISOR;
  logic       BUSY, DONE, DIV_ZERO;
  logic [3:0] QUOTIENT, REMAINDER;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] prev_q, prev_r;
  logic       prev_dz;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_q;
    logic [3:0] exp_r;
    logic       exp_dz;
    int         exp_lat;
  } vec_t;

  vec_t vecs[6];

  seq_divider_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .DIVIDEND  (DIVIDEND),
    .DIVISOR   (DIVISOR),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .QUOTIENT  (QUOTIENT),
    .REMAINDER (REMAINDER),
    .DIV_ZERO  (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer division, divide by zero yields {dz, F, dividend}.
  function automatic logic [8:0] ref_div(input logic [3:0] a, input logic [3:0] b);
    int qi, ri;
    if (b == 4'd0) return {1'b1, 4'hF, a};
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
    return {1'b0, 4'(qi), 4'(ri)};
  endfunction

  // Counts edges (sampled #1 after each) until DONE, up to a budget of 10.
  task automatic wait_done(output int n, output int busy_n, output bit hold_ok, output bit ovl);
    n = 0; busy_n = 0; hold_ok = 1'b1; ovl = 1'b0;
    while (n < 10) begin
      @(posedge CLK); #1;
      n++;
      if (BUSY && DONE) ovl = 1'b1;
      if (DONE) break;
      if (BUSY) busy_n++;
      if (QUOTIENT !== prev_q || REMAINDER !== prev_r || DIV_ZERO !== prev_dz) hold_ok = 1'b0;
      if (START) START = 1'b0;
    end
  endtask

  task automatic do_div(input logic [3:0] a, input logic [3:0] b, input logic [3:0] eq,
                        input logic [3:0] er, input logic edz, input int elat, input string tag);
    int n, busy_n;
    bit hold_ok, ovl;
    @(negedge CLK);
    START = 1'b1; DIVIDEND = a; DIVISOR = b;
    wait_done(n, busy_n, hold_ok, ovl);
    START = 1'b0;
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_busy"}, busy_n, elat - 1);
    chk({tag, "_res"}, {DIV_ZERO, QUOTIENT, REMAINDER}, {edz, eq, er});
    chk({tag, "_hold"}, hold_ok, 1'b1);
    chk({tag, "_ovl"}, ovl, 1'b0);
    @(posedge CLK); #1;
    chk({tag, "_done1"}, DONE, 1'b0);
    prev_q = eq; prev_r = er; prev_dz = edz;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] m;
    int n, busy_n;
    bit hold_ok, ovl;

    vecs[0] = '{4'd13, 4'd4,  4'd3,  4'd1, 1'b0, 5};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0, 1'b0, 5};
    vecs[2] = '{4'd3,  4'd7,  4'd0,  4'd3, 1'b0, 5};
    vecs[3] = '{4'd15, 4'd15, 4'd1,  4'd0, 1'b0, 5};
    vecs[4] = '{4'd0,  4'd5,  4'd0,  4'd0, 1'b0, 5};
    vecs[5] = '{4'd9,  4'd0,  4'hF,  4'd9, 1'b1, 1};

    RST_N = 1'b0; START = 1'b0; DIVIDEND = 4'd0; DIVISOR = 4'd0;
    prev_q = 4'd0; prev_r = 4'd0; prev_dz = 1'b0;
    #1;
    chk("reset_async", {BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER}, 11'd0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("reset_idle", {BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER}, 11'd0);

    for (int i = 0; i < 6; i++)
      do_div(vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r, vecs[i].exp_dz, vecs[i].exp_lat, "tbl");

    // Valid divide after divide-by-zero clears the flag.
    do_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 5, "dz_clear");

    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        m = ref_div(4'(a), 4'(b));
        do_div(4'(a), 4'(b), m[7:4], m[3:0], m[8], 5, "sweep");
      end

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      m = ref_div(ra, rb);
      repeat ($urandom_range(0, 2)) @(posedge CLK);
      do_div(ra, rb, m[7:4], m[3:0], m[8], (rb == 4'd0) ? 1 : 5, "rand");
    end

    // START pulsed mid-run with different operands must be ignored.
    @(negedge CLK);
    START = 1'b1; DIVIDEND = 4'd9; DIVISOR = 4'd2;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    START = 1'b1; DIVIDEND = 4'd15; DIVISOR = 4'd3;
    wait_done(n, busy_n, hold_ok, ovl);
    START = 1'b0;
    chk("ign_lat", n, 3);
    chk("ign_res", {DIV_ZERO, QUOTIENT, REMAINDER}, {1'b0, 4'd4, 4'd1});
    chk("ign_hold", hold_ok, 1'b1);
    prev_q = 4'd4; prev_r = 4'd1; prev_dz = 1'b0;

    // Back-to-back: START presented during the DONE cycle.
    @(posedge CLK); #1;
    @(negedge CLK);
    START = 1'b1; DIVIDEND = 4'd9; DIVISOR = 4'd2;
    wait_done(n, busy_n, hold_ok, ovl);
    chk("b2b_first", {n, DIV_ZERO, QUOTIENT, REMAINDER}, {32'd5, 1'b0, 4'd4, 4'd1});
    START = 1'b1; DIVIDEND = 4'd14; DIVISOR = 4'd3;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("b2b_restart", {BUSY, DONE}, 2'b10);
    wait_done(n, busy_n, hold_ok, ovl);
    chk("b2b_lat", n, 4);
    chk("b2b_res", {DIV_ZERO, QUOTIENT, REMAINDER}, {1'b0, 4'd4, 4'd2});
    @(posedge CLK); #1;
    chk("b2b_done1", DONE, 1'b0);
    prev_q = 4'd4; prev_r = 4'd2; prev_dz = 1'b0;

    // Asynchronous reset during iteration 3 aborts without a DONE.
    @(negedge CLK);
    START = 1'b1; DIVIDEND = 4'd13; DIVISOR = 4'd4;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_async", {BUSY, DONE, DIV_ZERO, QUOTIENT, REMAINDER}, 11'd0);
    ovl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) ovl = 1'b1;
    end
    @(negedge CLK); RST_N = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) ovl = 1'b1;
    end
    chk("abort_no_done", ovl, 1'b0);
    prev_q = 4'd0; prev_r = 4'd0; prev_dz = 1'b0;
    do_div(4'd7, 4'd2, 4'd3, 4'd1, 1'b0, 5, "after_abort");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
